// File: rtl/data_matrix_pc_ras_pkg.sv
// Shared definitions for the PC / return-address-stack unit.
package data_matrix_pc_ras_pkg;

  localparam int DEF_AW = 16;

  typedef enum logic [1:0] {
    PC_SEL_INC = 2'b00,
    PC_SEL_BUS = 2'b01,
    PC_SEL_EA  = 2'b10,
    PC_SEL_RAS = 2'b11
  } pc_sel_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_matrix_ras.sv
// Circular return-address stack with saturating occupancy and sticky error flags.
module data_matrix_ras
  import data_matrix_pc_ras_pkg::*;
#(
  parameter  int AW    = DEF_AW,
  parameter  int DEPTH = 4,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,     // already qualified by stall
  input  logic          i_pop,      // already qualified by stall
  input  logic          i_unf_evt,  // RAS-sourced PC load while empty
  input  logic          i_clr_err,
  input  logic [AW-1:0] i_din,
  output logic [AW-1:0] o_top,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ovf,
  output logic          o_unf
);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-1:0] w_sp_m1;
  logic          w_empty;
  logic          w_full;
  logic          w_replace;
  logic [PW-1:0] w_wr_idx;
  logic          w_ovf_evt;
  logic          w_unf_evt;

  assign w_sp_m1   = r_sp - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(DEPTH));
  // Push+pop on a non-empty stack rewrites the top in place; on an empty
  // stack it degenerates to a plain push.
  assign w_replace = i_push & i_pop & ~w_empty;
  assign w_wr_idx  = w_replace ? w_sp_m1 : r_sp;
  assign w_ovf_evt = i_push & ~i_pop & w_full;
  assign w_unf_evt = (i_pop & w_empty) | i_unf_evt;

  // Stack pointer, occupancy and sticky flags (set wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (i_push && !w_replace) begin
        r_sp <= r_sp + PW'(1);
        if (!w_full) r_cnt <= r_cnt + CW'(1);
      end else if (i_pop && !i_push && !w_empty) begin
        r_sp  <= w_sp_m1;
        r_cnt <= r_cnt - CW'(1);
      end
      r_ovf <= (r_ovf & ~i_clr_err) | w_ovf_evt;
      r_unf <= (r_unf & ~i_clr_err) | w_unf_evt;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_din;
  end

  assign o_top   = w_empty ? '0 : r_mem[w_sp_m1];
  assign o_cnt   = r_cnt;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

endmodule

// File: rtl/data_matrix_pc_ras.sv
// Program-counter register with four-way source mux and a return-address stack.
module data_matrix_pc_ras
  import data_matrix_pc_ras_pkg::*;
#(
  parameter  int            AW        = DEF_AW,
  parameter  int            RAS_DEPTH = 4,
  parameter  int            PC_INC    = 1,
  parameter  logic [AW-1:0] RST_PC    = '0,
  localparam int            CW        = clog2(RAS_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] bus,
  input  logic [AW-1:0] ea,
  input  logic          ld_pc,
  input  logic [1:0]    pc_sel,
  input  logic          push,
  input  logic          pop,
  input  logic          stall,
  input  logic          clr_err,
  output logic [AW-1:0] reg_pc,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_minus_one,
  output logic [AW-1:0] ras_top,
  output logic [CW-1:0] ras_cnt,
  output logic          ras_full,
  output logic          ras_empty,
  output logic          ras_ovf,
  output logic          ras_unf
);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_mux;
  logic          w_ld;
  logic          w_push;
  logic          w_pop;
  logic          w_ras_unf_evt;

  assign w_ld          = ld_pc & ~stall;
  assign w_push        = push & ~stall;
  assign w_pop         = pop & ~stall;
  assign w_ras_unf_evt = w_ld & (pc_selE() == PC_SEL_RAS) & ras_empty;

  function automatic pc_sel_e pc_selE();
    return pc_sel_e'(pc_sel);
  endfunction

  // Next-PC source selection; an empty stack falls back to the bus.
  always_comb begin
    w_pc_mux = r_pc + AW'(PC_INC);
    case (pc_selE())
      PC_SEL_INC: w_pc_mux = r_pc + AW'(PC_INC);
      PC_SEL_BUS: w_pc_mux = bus;
      PC_SEL_EA:  w_pc_mux = ea;
      PC_SEL_RAS: w_pc_mux = ras_empty ? bus : ras_top;
      default:    w_pc_mux = r_pc + AW'(PC_INC);
    endcase
  end

  // PC register: loads the selected source unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RST_PC;
    else if (w_ld) r_pc <= w_pc_mux;
  end

  data_matrix_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_unf_evt (w_ras_unf_evt),
    .i_clr_err (clr_err),
    .i_din     (r_pc),
    .o_top     (ras_top),
    .o_cnt     (ras_cnt),
    .o_full    (ras_full),
    .o_empty   (ras_empty),
    .o_ovf     (ras_ovf),
    .o_unf     (ras_unf)
  );

  assign reg_pc       = r_pc;
  assign pc           = r_pc;
  assign pc_minus_one = r_pc - AW'(1);

endmodule

// File: tb/tb_data_matrix_pc_ras.sv
// Bench for data_matrix_pc_ras: vector table through a scoreboard queue, plus reset sequences.
module tb_data_matrix_pc_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus, ea;
  logic        ld_pc, push, pop, stall, clr_err;
  logic [1:0]  pc_sel;
  logic [15:0] reg_pc, pc, pc_minus_one, ras_top;
  logic [2:0]  ras_cnt;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ld;
    logic [1:0]  sel;
    logic        psh;
    logic        pp;
    logic        stl;
    logic        clr;
    logic [15:0] bus;
    logic [15:0] ea;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic [15:0] e_top;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];

  data_matrix_pc_ras #(
    .AW(16), .RAS_DEPTH(4), .PC_INC(1), .RST_PC(16'h3000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ea(ea), .ld_pc(ld_pc), .pc_sel(pc_sel),
    .push(push), .pop(pop), .stall(stall), .clr_err(clr_err),
    .reg_pc(reg_pc), .pc(pc), .pc_minus_one(pc_minus_one), .ras_top(ras_top),
    .ras_cnt(ras_cnt), .ras_full(ras_full), .ras_empty(ras_empty),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic ld, logic [1:0] sel, logic psh, logic pp, logic stl,
                              logic clr, logic [15:0] b, logic [15:0] e, logic [15:0] epc,
                              logic [2:0] ecnt, logic [15:0] etop, logic eovf, logic eunf);
    vec_t v;
    v.ld = ld; v.sel = sel; v.psh = psh; v.pp = pp; v.stl = stl; v.clr = clr;
    v.bus = b; v.ea = e; v.e_pc = epc; v.e_cnt = ecnt; v.e_top = etop;
    v.e_ovf = eovf; v.e_unf = eunf;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_state(input int idx, input vec_t v);
    chk("pc", idx, pc, v.e_pc);
    chk("reg_pc", idx, reg_pc, v.e_pc);
    chk("pc_minus_one", idx, pc_minus_one, v.e_pc - 16'd1);
    chk("ras_cnt", idx, {13'd0, ras_cnt}, {13'd0, v.e_cnt});
    chk("ras_top", idx, ras_top, v.e_top);
    chk("ras_full", idx, {15'd0, ras_full}, {15'd0, (v.e_cnt == 3'd4)});
    chk("ras_empty", idx, {15'd0, ras_empty}, {15'd0, (v.e_cnt == 3'd0)});
    chk("ras_ovf", idx, {15'd0, ras_ovf}, {15'd0, v.e_ovf});
    chk("ras_unf", idx, {15'd0, ras_unf}, {15'd0, v.e_unf});
  endtask

  task automatic drive(input vec_t v);
    ld_pc = v.ld; pc_sel = v.sel; push = v.psh; pop = v.pp;
    stall = v.stl; clr_err = v.clr; bus = v.bus; ea = v.ea;
  endtask

  task automatic idle();
    ld_pc = 0; pc_sel = 0; push = 0; pop = 0; stall = 0; clr_err = 0; bus = 0; ea = 0;
  endtask

  initial begin
    vec_t got_v;
    idle();
    rst_n = 1'b0;

    //          ld sel   ps pp st cl bus       ea        pc        cnt top      ovf unf
    tv.push_back(mk(1, 2'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3001, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3002, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3003, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3004, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h3005, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 2'd0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h3005, 1, 16'h3005, 0, 0));
    tv.push_back(mk(1, 2'd2, 0, 0, 0, 0, 16'h0000, 16'h5000, 16'h5000, 1, 16'h3005, 0, 0));
    tv.push_back(mk(1, 2'd3, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h3005, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd3, 0, 0, 0, 0, 16'h2222, 16'h0000, 16'h2222, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 2'd0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h2222, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd1, 0, 0, 0, 0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd1, 0, 0, 0, 0, 16'h1234, 16'h0000, 16'h1234, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd1, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0010, 0, 16'h0000, 0, 0));
    tv.push_back(mk(1, 2'd1, 1, 0, 0, 0, 16'h0011, 16'h0000, 16'h0011, 1, 16'h0010, 0, 0));
    tv.push_back(mk(1, 2'd1, 1, 0, 0, 0, 16'h0012, 16'h0000, 16'h0012, 2, 16'h0011, 0, 0));
    tv.push_back(mk(1, 2'd1, 1, 0, 0, 0, 16'h0013, 16'h0000, 16'h0013, 3, 16'h0012, 0, 0));
    tv.push_back(mk(1, 2'd1, 1, 0, 0, 0, 16'h0014, 16'h0000, 16'h0014, 4, 16'h0013, 0, 0));
    tv.push_back(mk(0, 2'd0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0014, 4, 16'h0014, 1, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0014, 3, 16'h0013, 1, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0014, 2, 16'h0012, 1, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0014, 1, 16'h0011, 1, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0014, 0, 16'h0000, 1, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0014, 0, 16'h0000, 1, 1));
    tv.push_back(mk(0, 2'd0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0014, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0014, 0, 16'h0000, 0, 1));
    tv.push_back(mk(0, 2'd0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0014, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 2'd0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0014, 1, 16'h0014, 0, 0));
    tv.push_back(mk(1, 2'd1, 1, 0, 0, 0, 16'h0777, 16'h0000, 16'h0777, 2, 16'h0014, 0, 0));
    tv.push_back(mk(0, 2'd0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0777, 2, 16'h0777, 0, 0));
    tv.push_back(mk(1, 2'd0, 1, 1, 1, 0, 16'h5555, 16'h0000, 16'h0777, 2, 16'h0777, 0, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0777, 1, 16'h0014, 0, 0));
    tv.push_back(mk(0, 2'd0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0777, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 2'd0, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0777, 1, 16'h0777, 0, 1));
    tv.push_back(mk(1, 2'd3, 1, 1, 1, 1, 16'h0000, 16'h0000, 16'h0777, 1, 16'h0777, 0, 0));

    // Reset release away from the clock edge; outputs valid immediately.
    #12 rst_n = 1'b1;
    #1;
    chk_state(-1, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h3000, 0, 16'h0000, 0, 0));

    foreach (tv[i]) begin
      drive(tv[i]);
      exp_q.push_back(tv[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard[%0d] got=empty exp=entry", i);
      end else begin
        got_v = exp_q.pop_front();
        chk_state(i, got_v);
      end
    end

    // Asynchronous reset mid-sequence: takes effect before any clock edge.
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 0, pc, 16'h3000);
    chk("async_rst_cnt", 0, {13'd0, ras_cnt}, 16'd0);
    chk("async_rst_top", 0, ras_top, 16'h0000);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(mk(1, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk_state(100, mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h3001, 1, 16'h3000, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_matrix_pc_ras.md
Name: data_matrix_pc_ras

Overview:
Parametrised program-counter unit for the LC-3 datapath. It generalises the PC load path to configurable address width, increment step and a fourth PC source. It adds a small hardware return-address stack (RAS) that is pushed on JSR/JSRR and popped on RET. The block sits in the data matrix between the bus/EA generators and the fetch logic, and drives pc, pc_minus_one and the stack status to the control FSM.

Parameters:
AW, 16, address/PC width in bits (>=8)
RAS_DEPTH, 4, number of return-address entries (power of two, 2..16)
PC_INC, 1, increment applied for the sequential source (1..2^(AW-1)-1)
RST_PC, 16'h0000, reset value of reg_pc (width AW)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
bus  input  AW  PC source 01; also the RET fallback when the RAS is empty
ea  input  AW  PC source 10 (effective address)
ld_pc  input  1  load reg_pc from the selected source
pc_sel  input  2  00 inc, 01 bus, 10 ea, 11 RAS top
push  input  1  push current reg_pc onto the RAS (JSR/JSRR)
pop  input  1  discard the RAS top (RET)
stall  input  1  freeze: ld_pc, push and pop have no effect
clr_err  input  1  clear sticky error flags
reg_pc  output  AW  PC register
pc  output  AW  equals reg_pc
pc_minus_one  output  AW  reg_pc - 1, modulo 2^AW
ras_top  output  AW  newest RAS entry; 0 when empty
ras_cnt  output  clog2(RAS_DEPTH)+1  valid entries, 0..RAS_DEPTH
ras_full  output  1  ras_cnt == RAS_DEPTH
ras_empty  output  1  ras_cnt == 0
ras_ovf  output  1  sticky: push occurred while full
ras_unf  output  1  sticky: pop or RAS-sourced load occurred while empty

Behaviour:
- Reset (asynchronous, rst_n low): reg_pc=RST_PC, ras_cnt=0, stack pointer=0, ras_ovf=0, ras_unf=0. Stack memory contents are don't-care. An in-flight push or pop is lost. All outputs are valid in the first cycle after release.
- pc_mux (combinational):
  - 00: reg_pc+PC_INC, truncated to AW bits (wraps).
  - 01: bus.
  - 10: ea.
  - 11: ras_top if not empty, else bus.
- reg_pc <= pc_mux at the clock edge when ld_pc && !stall; otherwise it holds. Latency from load to pc is 1 cycle.
- Push (push && !stall): mem[sp] <= reg_pc (value before any same-cycle load); sp <= sp+1 mod RAS_DEPTH; ras_cnt saturates at RAS_DEPTH.
  - When full, the push overwrites the oldest entry (circular) and sets ras_ovf.
- Pop (pop && !stall): if ras_cnt>0, sp <= sp-1 and ras_cnt decrements. If empty, there is no state change and ras_unf is set.
- ras_unf is also set when ld_pc && pc_sel==11 && ras_empty && !stall.
- Push and pop in the same cycle: mem[sp-1] <= reg_pc (top replaced); sp and ras_cnt are unchanged.
  - When empty, this case behaves as a plain push, and ras_unf is set.
- ras_top = mem[sp-1] when ras_cnt>0, else 0. It is combinational from registered state.
- pc_sel==11 with ld_pc and pop in the same cycle: reg_pc loads the pre-pop ras_top.
- clr_err clears both sticky flags. If a new error event occurs in the same cycle, setting wins.
- stall has priority over every state update except reset. clr_err works during stall.
- pc_minus_one of 0 gives all ones (2^AW-1).

Decomposition:
- Shared package: PC_SEL_INC/BUS/EA/RAS encodings, the default AW, and a clog2 function.
- Sub-module data_matrix_ras: circular LIFO holding mem, sp, cnt, full/empty and the sticky flags. It has push, pop, din and top ports. The top level keeps reg_pc and pc_mux.

Test Plan:
- Reset, then 3 cycles of ld_pc with sel=00 (AW=16, RST_PC=0x3000) -> pc=0x3001,0x3002,0x3003; pc_minus_one=0x3002 after the last.
- reg_pc=0xFFFF, ld_pc, sel=00 -> pc=0x0000, pc_minus_one=0xFFFF. Separately, sel=01 with bus=0x1234 -> pc=0x1234; sel=10 with ea=0x4000 -> pc=0x4000.
- Push at pc=0x3005, load ea=0x5000, then ld_pc sel=11 with pop -> pc=0x3005, ras_empty=1, ras_unf=0.
- RAS_DEPTH=4, 5 pushes of 0x10..0x14 -> ras_full=1, ras_ovf=1, ras_cnt=4. Four pops yield tops 0x14,0x13,0x12,0x11, then ras_empty=1.
- Empty RAS, ld_pc sel=11, bus=0x2222 -> pc=0x2222 and ras_unf=1. Then clr_err -> ras_unf=0 the next cycle.
- stall=1 with ld_pc, push and pop all asserted -> pc, ras_cnt and flags unchanged. Push+pop with cnt=2 -> top=reg_pc, cnt stays 2. Assert rst_n low mid-sequence -> pc=RST_PC and cnt=0 immediately.
